// File: rtl/pipe_dmem.sv
// Pipeline data-memory stage: byte-lane stores, aligned and extended loads with one-cycle
// response, alignment/range fault detection and first-fault address capture.
module pipe_dmem #(
    parameter int ADDR_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        w,
    input  logic        h,
    input  logic        b,
    input  logic        z,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        err_clr,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        AddressErr,
    output logic        bad_valid,
    output logic [31:0] badvaddr
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-3:0] widx;
    logic                  accept;
    logic                  size_bad;
    logic                  misalign;
    logic                  out_of_range;
    logic                  fault;
    logic                  do_write;
    logic [3:0]            lane_en;
    logic [31:0]           wlanes;
    logic [31:0]           rword;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;
    logic [31:0]           load_data;

    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  addr_err_q, addr_err_d;
    logic                  bad_valid_q, bad_valid_d;
    logic [31:0]           badvaddr_q, badvaddr_d;

    assign accept       = req_valid & ~stall;
    assign widx         = addr[ADDR_WIDTH-1:2];
    assign out_of_range = |(addr >> ADDR_WIDTH);
    assign misalign     = (h & addr[0]) | (w & (addr[1:0] != 2'b00));
    assign fault        = size_bad | misalign | out_of_range;
    // rst must also block the write of a request presented in the reset cycle
    assign do_write     = accept & ~fault & req_we & ~rst;

    always_comb begin
        case ({w, h, b})
            3'b100, 3'b010, 3'b001: size_bad = 1'b0;
            default:                size_bad = 1'b1;
        endcase
    end

    always_comb begin
        lane_en = 4'b0000;
        wlanes  = wdata;
        if (w) begin
            lane_en = 4'b1111;
        end else if (h) begin
            lane_en = addr[1] ? 4'b1100 : 4'b0011;
            wlanes  = {2{wdata[15:0]}};
        end else begin
            lane_en = 4'b0001 << addr[1:0];
            wlanes  = {4{wdata[7:0]}};
        end
    end

    assign rword    = mem_q[widx];
    assign half_sel = addr[1] ? rword[31:16] : rword[15:0];
    assign byte_sel = rword[8*addr[1:0] +: 8];

    always_comb begin
        if (w) begin
            load_data = rword;
        end else if (h) begin
            load_data = z ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        end else begin
            load_data = z ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    mem_q[widx][8*k +: 8] <= wlanes[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        addr_err_d  = addr_err_q;
        if (!stall) begin
            rsp_valid_d = req_valid;
            addr_err_d  = req_valid & fault;
            rdata_d     = (req_valid & ~fault & ~req_we) ? load_data : 32'h0;
        end
    end

    // Clear first, so a fault arriving with err_clr is captured as the new first fault
    always_comb begin
        bad_valid_d = bad_valid_q & ~err_clr;
        badvaddr_d  = badvaddr_q;
        if (accept && fault && !bad_valid_d) begin
            bad_valid_d = 1'b1;
            badvaddr_d  = addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            addr_err_q  <= 1'b0;
            bad_valid_q <= 1'b0;
            badvaddr_q  <= 32'h0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            bad_valid_q <= bad_valid_d;
            badvaddr_q  <= badvaddr_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rdata      = rdata_q;
    assign AddressErr = addr_err_q;
    assign bad_valid  = bad_valid_q;
    assign badvaddr   = badvaddr_q;

endmodule
